// File: rtl/memory_access.sv
// Y86 memory stage: decodes the executed instruction into at most one data
// memory access, waits for ack/error/timeout, and reports a status code.
module memory_access #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [63:0] valM_o,
    output logic        done_o,
    output logic        busy_o,
    output logic [1:0]  stat_o
);

    localparam int unsigned CW       = $clog2(TIMEOUT + 1);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, DONE, STOP} state_t;

    typedef struct packed {
        logic        access;
        logic        we;
        logic [1:0]  stat;
        logic [63:0] addr;
        logic [63:0] wdata;
    } acc_req_t;

    state_t   state_q, state_d;
    acc_req_t dec;
    logic [1:0]    stat_d;
    logic [CW-1:0] cnt_q;
    logic          we_q;

    // Instruction decode; an illegal address cancels the access and flags ADR.
    always_comb begin
        dec       = '0;
        dec.stat  = STAT_AOK;
        dec.addr  = valE_i;
        dec.wdata = valA_i;
        case (icode_i)
            4'h4, 4'hA: begin dec.access = 1'b1; dec.we = 1'b1; end
            4'h8:       begin dec.access = 1'b1; dec.we = 1'b1; dec.wdata = valP_i; end
            4'h5:       dec.access = 1'b1;
            4'h9, 4'hB: begin dec.access = 1'b1; dec.addr = valA_i; end
            4'h1, 4'h2, 4'h3, 4'h6, 4'h7: ;
            4'h0:       dec.stat = STAT_HLT;
            default:    dec.stat = STAT_INS;
        endcase
        if (dec.access && ((dec.addr > MAX_ADDR) || (dec.addr[2:0] != 3'b000))) begin
            dec.access = 1'b0;
            dec.stat   = STAT_ADR;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_o;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = dec.access ? REQ : DONE;
                stat_d  = dec.stat;
            end
            REQ: begin
                if (mem_err_i) begin
                    state_d = DONE;
                    stat_d  = STAT_ADR;
                end else if (mem_ack_i) begin
                    state_d = DONE;
                    stat_d  = STAT_AOK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    stat_d  = STAT_ADR;
                end
            end
            DONE:    state_d = (stat_o == STAT_AOK) ? IDLE : STOP;
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            stat_o      <= STAT_AOK;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            valM_o      <= '0;
        end else begin
            state_q <= state_d;
            stat_o  <= stat_d;
            if (state_q == IDLE && start_i) begin
                we_q        <= dec.we;
                mem_addr_o  <= dec.addr;
                mem_wdata_o <= dec.wdata;
                cnt_q       <= '0;
            end else if (state_q == REQ && !mem_ack_i && !mem_err_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == REQ && mem_ack_i && !mem_err_i && !we_q)
                valM_o <= mem_rdata_i;
        end
    end

    assign mem_req_o = (state_q == REQ);
    assign mem_we_o  = mem_req_o & we_q;
    assign done_o    = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: decode, read/write, address errors,
// timeout, status/STOP behaviour and reset during a request.
module tb_memory_access;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0, err = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valE = '0, valA = '0, valP = '0, rdata = '0;
    logic        req, we, done, busy;
    logic [63:0] addr, wdata, valM;
    logic [1:0]  stat;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    memory_access #(.MEM_BYTES(1024), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode),
        .valE_i(valE), .valA_i(valA), .valP_i(valP),
        .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_ack_i(ack), .mem_rdata_i(rdata), .mem_err_i(err),
        .valM_o(valM), .done_o(done), .busy_o(busy), .stat_o(stat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; ack = 1'b0; err = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic launch(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
        icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if ({req, we, done, busy, stat} !== 6'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 000000", {req, we, done, busy, stat}); end
        n_cmp++; if ({addr, wdata, valM} !== 192'b0) begin n_bad++; $display("FAIL reset_data: got %h %h %h want 0", addr, wdata, valM); end
    endtask

    task automatic test_read();
        apply_reset();
        launch(4'h5, 64'h40, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({req, we, busy, addr} !== {3'b101, 64'h40}) begin n_bad++; $display("FAIL rd_req%0d: got %b%b%b %h want 101 40", i, req, we, busy, addr); end
            if (i == 2) begin ack = 1'b1; rdata = 64'h1122334455667788; end
            tick();
        end
        ack = 1'b0;
        n_cmp++; if ({done, req, stat} !== 4'b1000) begin n_bad++; $display("FAIL rd_done: got %b want 1000", {done, req, stat}); end
        n_cmp++; if (valM !== 64'h1122334455667788) begin n_bad++; $display("FAIL rd_valM: got %h want 1122334455667788", valM); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL rd_idle: got %b want 00", {done, busy}); end
    endtask

    task automatic test_write();
        apply_reset();
        launch(4'hA, 64'h3F8, 64'hAB, 64'h0);
        n_cmp++; if ({req, we, addr, wdata} !== {2'b11, 64'h3F8, 64'hAB}) begin n_bad++; $display("FAIL push_req: got %b%b %h %h want 11 3f8 ab", req, we, addr, wdata); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++; if ({done, stat} !== 3'b100) begin n_bad++; $display("FAIL push_done: got %b want 100", {done, stat}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL push_idle: got %b want 00", {busy, done}); end
    endtask

    task automatic test_decode();
        apply_reset();
        launch(4'hB, 64'h999, 64'h100, 64'h0);
        n_cmp++; if ({req, we, addr} !== {2'b10, 64'h100}) begin n_bad++; $display("FAIL pop_req: got %b%b %h want 10 100", req, we, addr); end
        ack = 1'b1; rdata = 64'h77; tick(); ack = 1'b0; tick();
        launch(4'h8, 64'h2F0, 64'h55, 64'h1234);
        n_cmp++; if ({req, we, addr, wdata} !== {2'b11, 64'h2F0, 64'h1234}) begin n_bad++; $display("FAIL call_req: got %b%b %h %h want 11 2f0 1234", req, we, addr, wdata); end
        ack = 1'b1; rdata = 64'hBAD; tick(); ack = 1'b0;
        n_cmp++; if ({done, stat, valM} !== {3'b100, 64'h77}) begin n_bad++; $display("FAIL call_done: got %b %h want 100 77", {done, stat}, valM); end
        tick();
        ack = 1'b1; rdata = 64'hFFFF; tick(); ack = 1'b0;
        n_cmp++; if ({busy, valM} !== {1'b0, 64'h77}) begin n_bad++; $display("FAIL idle_ack: got %b %h want 0 77", busy, valM); end
    endtask

    task automatic test_addr_err();
        apply_reset();
        launch(4'h4, 64'h400, 64'h1, 64'h0);
        n_cmp++; if ({req, done, stat} !== 4'b0110) begin n_bad++; $display("FAIL adr_hi: got %b want 0110", {req, done, stat}); end
        tick();
        n_cmp++; if ({busy, done, stat} !== 4'b1010) begin n_bad++; $display("FAIL adr_stop: got %b want 1010", {busy, done, stat}); end
        launch(4'h6, 64'h0, 64'h0, 64'h0);
        tick();
        n_cmp++; if ({busy, done, req, stat} !== 5'b10010) begin n_bad++; $display("FAIL stop_start: got %b want 10010", {busy, done, req, stat}); end
        apply_reset();
        launch(4'h5, 64'h44, 64'h0, 64'h0);
        n_cmp++; if ({req, done, stat} !== 4'b0110) begin n_bad++; $display("FAIL adr_align: got %b want 0110", {req, done, stat}); end
        apply_reset();
        launch(4'h5, 64'h8000_0000_0000_0040, 64'h0, 64'h0);
        n_cmp++; if ({req, done, stat} !== 4'b0110) begin n_bad++; $display("FAIL adr_wide: got %b want 0110", {req, done, stat}); end
    endtask

    task automatic test_timeout();
        int hi = 0;
        apply_reset();
        launch(4'h5, 64'h40, 64'h0, 64'h0);
        ack = 1'b1; rdata = 64'hCAFE; tick(); ack = 1'b0; tick();
        launch(4'h5, 64'h80, 64'h0, 64'h0);
        for (int i = 0; i < 40 && req === 1'b1; i++) begin hi++; tick(); end
        n_cmp++; if (hi != 16) begin n_bad++; $display("FAIL to_cycles: got %0d want 16", hi); end
        n_cmp++; if ({done, stat, valM} !== {3'b110, 64'hCAFE}) begin n_bad++; $display("FAIL to_done: got %b %h want 110 cafe", {done, stat}, valM); end
        tick();
        n_cmp++; if ({busy, req} !== 2'b10) begin n_bad++; $display("FAIL to_stop: got %b want 10", {busy, req}); end
    endtask

    task automatic test_ack_at_limit();
        apply_reset();
        launch(4'h5, 64'h88, 64'h0, 64'h0);
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL lim_req: got %b want 1", req); end
        ack = 1'b1; rdata = 64'h0123; tick(); ack = 1'b0;
        n_cmp++; if ({done, stat, valM} !== {3'b100, 64'h0123}) begin n_bad++; $display("FAIL lim_ack: got %b %h want 100 123", {done, stat}, valM); end
    endtask

    task automatic test_mem_err();
        apply_reset();
        launch(4'h5, 64'h40, 64'h0, 64'h0);
        ack = 1'b1; rdata = 64'h99; tick(); ack = 1'b0; tick();
        launch(4'h9, 64'h0, 64'h48, 64'h0);
        ack = 1'b1; err = 1'b1; rdata = 64'h5555; tick(); ack = 1'b0; err = 1'b0;
        n_cmp++; if ({done, stat, valM} !== {3'b110, 64'h99}) begin n_bad++; $display("FAIL err_done: got %b %h want 110 99", {done, stat}, valM); end
    endtask

    task automatic test_nonaccess();
        apply_reset();
        launch(4'h6, 64'h0, 64'h0, 64'h0);
        n_cmp++; if ({done, req, stat} !== 4'b1000) begin n_bad++; $display("FAIL opq_done: got %b want 1000", {done, req, stat}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL opq_idle: got %b want 00", {busy, done}); end
        launch(4'h0, 64'h0, 64'h0, 64'h0);
        n_cmp++; if ({done, stat} !== 3'b101) begin n_bad++; $display("FAIL halt: got %b want 101", {done, stat}); end
        tick();
        n_cmp++; if ({busy, done, stat} !== 4'b1001) begin n_bad++; $display("FAIL halt_stop: got %b want 1001", {busy, done, stat}); end
        apply_reset();
        launch(4'hD, 64'h0, 64'h0, 64'h0);
        n_cmp++; if ({done, stat} !== 3'b111) begin n_bad++; $display("FAIL ins: got %b want 111", {done, stat}); end
        tick();
        n_cmp++; if ({busy, done, stat} !== 4'b1011) begin n_bad++; $display("FAIL ins_stop: got %b want 1011", {busy, done, stat}); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        launch(4'h5, 64'h10, 64'h0, 64'h0);
        icode = 4'h6; start = 1'b1; ack = 1'b1; rdata = 64'h42; tick(); ack = 1'b0;
        n_cmp++; if ({done, valM} !== {1'b1, 64'h42}) begin n_bad++; $display("FAIL b2b_done: got %b %h want 1 42", done, valM); end
        start = 1'b0; tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_noqueue: got %b want 00", {busy, done}); end
    endtask

    task automatic test_reset_in_req();
        apply_reset();
        launch(4'h5, 64'h40, 64'h0, 64'h0);
        ack = 1'b1; rdata = 64'hDEAD; tick(); ack = 1'b0; tick();
        launch(4'h5, 64'h50, 64'h0, 64'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if ({req, we, done, busy, stat, addr, valM} !== 134'b0) begin n_bad++; $display("FAIL rreq_rst: got %b %h %h want 0", {req, we, done, busy, stat}, addr, valM); end
        ack = 1'b1; rdata = 64'hBEEF; tick(); ack = 1'b0;
        n_cmp++; if ({req, done, busy, stat, valM} !== 69'b0) begin n_bad++; $display("FAIL rreq_ack: got %b %h want 0", {req, done, busy, stat}, valM); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode();
        test_addr_err();
        test_timeout();
        test_ack_at_limit();
        test_mem_err();
        test_nonaccess();
        test_back_to_back();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter MEM_BYTES, 1024: data memory size in bytes; valid addresses 0..MEM_BYTES-8.
REQ-002 Parameter TIMEOUT, 16: maximum REQ cycles without ack before an address error.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  execute-stage result valid; sampled only in IDLE.
REQ-006 icode_i  in  4  Y86 icode from the execute stage.
REQ-007 valE_i  in  64  ALU result (address or stack pointer) from the execute stage.
REQ-008 valA_i  in  64  register operand (store data, or pop/ret address).
REQ-009 valP_i  in  64  next-PC value (call return address).
REQ-010 mem_req_o  out  1  data memory request.
REQ-011 mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o=1.
REQ-012 mem_addr_o  out  64  access byte address.
REQ-013 mem_wdata_o  out  64  write data.
REQ-014 mem_ack_i  in  1  memory completion, one cycle.
REQ-015 mem_rdata_i  in  64  read data; valid with mem_ack_i.
REQ-016 mem_err_i  in  1  memory fault; valid with or instead of mem_ack_i.
REQ-017 valM_o  out  64  read result, held until the next read completes.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 stat_o  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS.

Function
REQ-021 FSM states: IDLE, REQ, DONE, STOP.
REQ-022 Access decode for the instruction latched at start:
- rmmovq (4), pushq (A): write valA_i to valE_i.
- call (8): write valP_i to valE_i.
- mrmovq (5): read from valE_i.
- popq (B), ret (9): read from valA_i.
- icodes 1, 2, 3, 6, 7: no access.
- halt (0): no access, HLT.
- icode C..F: INS.
REQ-023 IDLE with start_i=1 latches icode, address and write data in that cycle.
REQ-024 Non-access instruction: IDLE -> DONE; done_o high the following cycle (latency 1).
REQ-025 Address check at start: address > MEM_BYTES-8 or address[2:0] != 0 -> ADR, no request issued, IDLE -> DONE.
REQ-026 Legal access: IDLE -> REQ; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stable from the next cycle until ack, error or timeout.
REQ-027 REQ behaviour:
- mem_ack_i=1 with mem_err_i=0: AOK; for reads, valM_o <= mem_rdata_i; -> DONE.
- mem_err_i=1 (with or without ack): ADR; valM_o unchanged; -> DONE.
REQ-028 REQ cycle counter: cleared on entry to REQ, incremented each cycle without ack or error; when it reaches TIMEOUT: ADR, mem_req_o drops, -> DONE.
REQ-029 Ack in the same cycle the counter reaches TIMEOUT: the ack wins.
REQ-030 DONE: done_o=1 for exactly one cycle, stat_o updated.
- stat AOK: DONE -> IDLE.
- stat HLT, ADR or INS: DONE -> STOP.
REQ-031 STOP: busy_o=1, start_i ignored, no requests, stat_o held; left only by rst_i.
REQ-032 start_i in REQ, DONE or STOP is ignored and not queued.
REQ-033 mem_ack_i or mem_err_i outside REQ is ignored.
REQ-034 mem_req_o is low in every state except REQ; at most one outstanding request.
REQ-035 Addresses are compared unsigned, at full 64-bit width.

Reset
REQ-036 rst_i=1 at a clock edge: state IDLE; mem_req_o, mem_we_o, done_o, busy_o = 0; mem_addr_o, mem_wdata_o, valM_o = 0; stat_o = 00; counter = 0.
REQ-037 Reset takes priority over every event, including reset asserted in REQ: the request drops the next cycle and a later ack is ignored.

Verification
REQ-038 mrmovq, valE=0x40, ack after 3 cycles with rdata=0x1122334455667788 -> mem_we_o=0, mem_addr_o=0x40; valM_o=0x1122334455667788; single done_o pulse; stat_o=00.
REQ-039 pushq, valE=0x3F8, valA=0xAB, ack after 1 cycle -> mem_we_o=1, mem_addr_o=0x3F8, mem_wdata_o=0xAB; stat_o=00; returns to IDLE.
REQ-040 rmmovq, valE=0x400 (MEM_BYTES=1024) -> no mem_req_o; done_o one cycle after start; stat_o=10; then STOP, and a later start_i is ignored.
REQ-041 mrmovq with no ack -> mem_req_o high for exactly 16 cycles; stat_o=10; valM_o unchanged.
REQ-042 opq (6) -> done_o one cycle after start, no request, stat_o=00; icode 0 -> stat_o=01 and STOP; icode D -> stat_o=11 and STOP.
REQ-043 rst_i asserted during REQ with ack arriving one cycle later -> all outputs 0, IDLE, valM_o=0, no done_o pulse.
